// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the boot/reset controller
package boot_pkg;

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      DATA   = 3'd2,
      HOLD   = 3'd3,
      RUN    = 3'd4
   } boot_state_t;

   localparam int WORD_BYTES = 4;
   localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/boot_word_asm.sv
// rtl/boot_word_asm.sv - little-endian byte-to-word assembler
module boot_word_asm
   import boot_pkg::*;
(
   input  logic        clk_i,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   logic [IDX_W-1:0] byte_idx_q;
   logic [23:0]      shreg_q;

   // The final byte is not stored; it is combined straight into the output word.
   assign word_valid_o = byte_valid_i && (byte_idx_q == IDX_W'(WORD_BYTES - 1));
   assign word_o       = {byte_i, shreg_q};

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         byte_idx_q <= '0;
         shreg_q    <= '0;
      end else if (byte_valid_i) begin
         byte_idx_q <= byte_idx_q + 1'b1;
         shreg_q    <= {byte_i, shreg_q[23:8]};
      end
   end

endmodule

// File: rtl/boot_reset_ctrl.sv
// rtl/boot_reset_ctrl.sv - loads a length-prefixed image into imem, then releases core reset
module boot_reset_ctrl
   import boot_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int HOLD_CYCLES = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              core_rst_o,
   output logic              boot_done_o,
   output logic              overflow_o
);

   localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

   boot_state_t       state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       wcnt_q, wcnt_d;
   logic [15:0]       hold_q, hold_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ovf_q, ovf_d;
   logic              core_rst_q;

   logic              accept;
   logic              word_valid;
   logic [31:0]       word;
   logic              in_range;

   assign rx_ready_o = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
   assign accept     = rx_valid_i && rx_ready_o;
   assign in_range   = ({16'd0, wcnt_q} < (32'd1 << ADDR_W));

   // Assembler is held clear outside DATA so every image starts on a word boundary.
   boot_word_asm u_word_asm (
      .clk_i        (clk_i),
      .clear_i      (rst_i || (state_q != DATA)),
      .byte_valid_i (accept && (state_q == DATA)),
      .byte_i       (rx_data_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      case (state_q)
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx_data_i;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = rx_data_i;
               wcnt_d      = '0;
               if ({rx_data_i, len_q[7:0]} == 16'd0) begin
                  state_d = HOLD;
                  hold_d  = HOLD_INIT;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (word_valid) begin
               if (in_range) begin
                  we_d    = 1'b1;
                  addr_d  = wcnt_q[ADDR_W-1:0];
                  wdata_d = word;
               end else begin
                  ovf_d = 1'b1;
               end
               wcnt_d = wcnt_q + 16'd1;
               if (wcnt_q + 16'd1 == len_q) begin
                  state_d = HOLD;
                  hold_d  = HOLD_INIT;
               end
            end
         end
         HOLD: begin
            if (hold_q == 16'd0) state_d = RUN;
            else                 hold_d  = hold_q - 16'd1;
         end
         RUN:     state_d = RUN;
         default: state_d = LEN_LO;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= LEN_LO;
         len_q      <= '0;
         wcnt_q     <= '0;
         hold_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ovf_q      <= 1'b0;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wcnt_q     <= wcnt_d;
         hold_q     <= hold_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ovf_q      <= ovf_d;
         core_rst_q <= (state_d != RUN);
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign core_rst_o   = core_rst_q;
   assign boot_done_o  = (state_q == RUN);
   assign overflow_o   = ovf_q;

endmodule

// File: doc/boot_reset_ctrl.md
# boot_reset_ctrl

Boot and reset controller for the single-stage RISC-V top. It holds the core in reset, receives a length-prefixed program image as a byte stream, and writes it word by word into instruction memory from address 0. After the last word plus a fixed hold window, it releases the core reset. It drives the core's reset from inside the SoC, so program loading and reset release no longer depend on external stimulus.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Depth is 2^ADDR_W words.
- `HOLD_CYCLES`, default 5: cycles that `core_rst` stays high after the last image word is written. Must be at least 1.

Ports:
- `clk`  in  1: single clock domain. All logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_valid`  in  1: a byte is offered on `rx_data`.
- `rx_data`  in  8: image byte.
- `rx_ready`  out  1: the controller can accept a byte. A byte transfers on any cycle where `rx_valid && rx_ready`.
- `imem_we`  out  1: instruction-memory write strobe, one cycle wide.
- `imem_addr`  out  ADDR_W: word address.
- `imem_wdata`  out  32: word to write.
- `core_rst`  out  1: active-high reset to the core, registered.
- `boot_done`  out  1: the image has been loaded and the core is running.
- `overflow`  out  1: sticky flag. The image was longer than the memory.

## Operation
- Image frame format, in order:
  - 16-bit word count N, little-endian (low byte first).
  - N words, each 4 bytes, little-endian.
- FSM states: `LEN_LO`, `LEN_HI`, `DATA`, `HOLD`, `RUN`.
  - `LEN_LO`: accept a byte and latch it as `len[7:0]`, then go to `LEN_HI`.
  - `LEN_HI`: accept a byte and latch it as `len[15:8]`.
    - If the full length is 0, go to `HOLD`.
    - Otherwise clear the word counter and go to `DATA`.
  - `DATA`: accept bytes into the word assembler (`byte_idx` 0..3).
    - On the 4th byte, issue a write at word index `wcnt`, increment `wcnt`, and reset `byte_idx`.
    - When `wcnt` reaches N, go to `HOLD`.
  - `HOLD`: count down from HOLD_CYCLES. Go to `RUN` when the count expires.
  - `RUN`: terminal state. Only `rst` leaves it.
- `rx_ready` is high in `LEN_LO`, `LEN_HI` and `DATA`, and low otherwise. It is combinational from state only and never depends on `rx_valid`.
- Words with index ≥ 2^ADDR_W are consumed but not written (`imem_we` stays 0), and `overflow` is set. Loading still completes after N words.
- The word counter is 16 bits wide. `imem_addr` is `wcnt[ADDR_W-1:0]`, taken only while writes are enabled.
- `core_rst` is 1 in every state except `RUN`. `boot_done` is 1 only in `RUN`.
- `rx_valid` low in the middle of a word stalls assembly without losing bytes. There is no timeout.

## Timing
- Values on reset:
  - State returns to `LEN_LO`.
  - `core_rst` = 1, `boot_done` = 0, `overflow` = 0, `imem_we` = 0.
  - `imem_addr` = 0, `imem_wdata` = 0.
  - All counters are cleared.
- Reset clears no memory contents.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid in the cycle after the cycle in which the 4th byte is accepted.
- Release latency: the last write strobe occurs in cycle T. `HOLD` is entered in cycle T, and `core_rst` falls (with `boot_done` rising) in cycle T + HOLD_CYCLES.
- For N = 0: with `LEN_HI` accepted in cycle T, `core_rst` falls in cycle T + 1 + HOLD_CYCLES.
- Throughput: one byte per cycle. A new word can complete every 4 cycles back to back.
- `rst` asserted mid-operation:
  - Takes effect at the next edge. Any partially assembled word is discarded and no write is issued.
  - If `rst` is asserted in the same cycle that a strobe would be registered, the strobe is suppressed.
- `rst` while in `RUN` re-enters loading with `core_rst` = 1 on the next cycle.

## Structure
- Package `boot_pkg`:
  - State enum `boot_state_t`.
  - `WORD_BYTES` = 4.
  - `LEN_BYTES` = 2.
- Sub-module `boot_word_asm` (natural split):
  - Contains the byte shift register and the 2-bit `byte_idx`.
  - Asserts `word_valid` together with the assembled 32-bit word.
  - Has a clear input driven by `rst` and by the FSM.
- The top level holds the FSM, the length register, the word counter, the hold counter and the output registers.

## Test plan
- Reset held 5 cycles, no bytes:
  - `core_rst` = 1, `boot_done` = 0, `rx_ready` = 1, `imem_we` never asserted.
- Image `02 00 | 13 00 50 00 | 93 00 A0 00`:
  - Writes `addr 0 = 0x00500013` and `addr 1 = 0x00A00093`.
  - `core_rst` falls exactly 5 cycles after the second strobe.
- Zero-length image `00 00`:
  - No writes.
  - `core_rst` falls in cycle T+6, where the `LEN_HI` accept is cycle T.
- With ADDR_W = 2, N = 5 words:
  - Only addresses 0–3 are written.
  - `overflow` = 1 after the 5th word.
  - Boot still completes.
- Random `rx_valid` gaps (~50% duty) across the second example image:
  - Identical writes and data.
- `rst` asserted after 6 data bytes of a 2-word image:
  - No write for the partial word.
  - State returns to `LEN_LO`.
  - A full reload then succeeds from address 0.
